// File: rtl/vga_timing_gen_pkg.sv
// Timing constants for the 640x480 @ 60 Hz VGA raster generator.
// Holds default porch/sync widths, the counter width and derived
// totals and sync window positions.
package vga_timing_pkg;

   localparam int CNT_W = 11;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // Length of one axis period in counter steps.
   function automatic int axis_total(int visible, int front, int sync, int back);
      return visible + front + sync + back;
   endfunction

   localparam int H_TOTAL      = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
   localparam int V_TOTAL      = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
   localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
   localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: syncs, beam position and visibility qualifier.
// frame_start exists only when VGA_TIMING_FRAME_START_EN is defined.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic             VGA_HSYNC;
   logic             VGA_VSYNC;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             on_screen;
`ifdef VGA_TIMING_FRAME_START_EN
   logic             frame_start;
`endif

   modport master (
      output VGA_HSYNC, VGA_VSYNC, pixel_x, pixel_y, on_screen
`ifdef VGA_TIMING_FRAME_START_EN
      , output frame_start
`endif
   );

   modport slave (
      input VGA_HSYNC, VGA_VSYNC, pixel_x, pixel_y, on_screen
`ifdef VGA_TIMING_FRAME_START_EN
      , input frame_start
`endif
   );

endinterface

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter with registered active-low
// sync and visible flags. Sync/visible are decoded from the next count so
// they always match the count held in the same flop stage.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             adv_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sync_n_o,
   output logic             vis_o,
   output logic             wrap_o
);

   localparam int               TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VISIBLE);
   localparam logic [CNT_W-1:0] SYNC_S  = CNT_W'(VISIBLE + FRONT);
   localparam logic [CNT_W-1:0] SYNC_E  = CNT_W'(VISIBLE + FRONT + SYNC);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync_n_q, sync_n_d;
   logic             vis_q, vis_d;

   // Wrap is qualified by the advance so the next axis steps exactly once.
   assign wrap_o = adv_i && (cnt_q == LAST);

   // Next count and the flags that belong to it.
   always_comb begin
      cnt_d = cnt_q;
      if (adv_i) cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
      sync_n_d = !((cnt_d >= SYNC_S) && (cnt_d < SYNC_E));
      vis_d    = (cnt_d < VIS_END);
   end

   // Reset parks on the last (blanked) position so the first edge lands on 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= LAST;
         sync_n_q <= 1'b1;
         vis_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sync_n_q <= sync_n_d;
         vis_q    <= vis_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign sync_n_o = sync_n_q;
   assign vis_o    = vis_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal counter runs every pixel clock,
// vertical counter steps on the horizontal wrap. All outputs come from flops.
// Optional frame_start pulse enabled by VGA_TIMING_FRAME_START_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic               CLK_PIXEL,
   input  logic               RST,
   vga_timing_gen_if.master   vga
);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_sync_n, v_sync_n;
   logic             h_vis, v_vis;
   logic             h_wrap, v_wrap;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK)
   ) u_h (
      .clk_i    (CLK_PIXEL),
      .rst_ni   (RST),
      .adv_i    (1'b1),
      .cnt_o    (h_cnt),
      .sync_n_o (h_sync_n),
      .vis_o    (h_vis),
      .wrap_o   (h_wrap)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK)
   ) u_v (
      .clk_i    (CLK_PIXEL),
      .rst_ni   (RST),
      .adv_i    (h_wrap),
      .cnt_o    (v_cnt),
      .sync_n_o (v_sync_n),
      .vis_o    (v_vis),
      .wrap_o   (v_wrap)
   );

   assign vga.pixel_x   = h_cnt;
   assign vga.pixel_y   = v_cnt;
   assign vga.VGA_HSYNC = h_sync_n;
   assign vga.VGA_VSYNC = v_sync_n;
   assign vga.on_screen = h_vis & v_vis;

`ifdef VGA_TIMING_FRAME_START_EN
   logic fs_q, fs_d;

   // Both axes wrapping together means the next position is (0,0).
   assign fs_d = h_wrap & v_wrap;

   // Register the pulse so it lines up with the (0,0) counter state.
   always_ff @(posedge CLK_PIXEL or negedge RST) begin
      if (!RST) fs_q <= 1'b0;
      else      fs_q <= fs_d;
   end

   assign vga.frame_start = fs_q;
`else
   // The vertical wrap only drives frame_start; sink it when that is absent.
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a shrunken
// instance (full frames fit in a short run) compared every cycle against an
// arithmetic model of raster position derived from edges since reset release.
module tb_vga_timing_gen;

   localparam int SHV = 20, SHF = 2, SHS = 3, SHB = 4;   // 29 clocks/line
   localparam int SVV = 6,  SVF = 1, SVS = 2, SVB = 3;   // 12 lines/frame
   localparam int SFRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   longint n = 0;          // rising edges seen with reset released
   int    checks = 0;
   int    failures = 0;

   always #10 clk = ~clk;

   vga_timing_gen_if vga0 ();
   vga_timing_gen_if vga1 ();

   vga_timing_gen u_dut0 (
      .CLK_PIXEL (clk),
      .RST       (rst_n),
      .vga       (vga0)
   );

   vga_timing_gen #(
      .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
      .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
   ) u_dut1 (
      .CLK_PIXEL (clk),
      .RST       (rst_n),
      .vga       (vga1)
   );

   logic [25:0] o0, o1;
   logic        fs0, fs1;
`ifdef VGA_TIMING_FRAME_START_EN
   assign fs0 = vga0.frame_start;
   assign fs1 = vga1.frame_start;
`else
   assign fs0 = 1'b0;
   assign fs1 = 1'b0;
`endif
   assign o0 = {fs0, vga0.pixel_x, vga0.pixel_y, vga0.VGA_HSYNC, vga0.VGA_VSYNC, vga0.on_screen};
   assign o1 = {fs1, vga1.pixel_x, vga1.pixel_y, vga1.VGA_HSYNC, vga1.VGA_VSYNC, vga1.on_screen};

   // Expected outputs after n released edges: position is (n-1) mod frame,
   // with n=0 meaning the last position of the frame.
   function automatic logic [25:0] ref_out(longint k, int hv, int hf, int hs, int hb,
                                           int vv, int vf, int vs, int vb);
      longint ht = hv + hf + hs + hb;
      longint vt = vv + vf + vs + vb;
      longint f  = ht * vt;
      longint p  = (k + f - 1) % f;
      longint x  = p % ht;
      longint y  = p / ht;
      logic   hsn = !((x >= hv + hf) && (x < hv + hf + hs));
      logic   vsn = !((y >= vv + vf) && (y < vv + vf + vs));
      logic   on  = (x < hv) && (y < vv);
      logic   fs  = 1'b0;
`ifdef VGA_TIMING_FRAME_START_EN
      fs = (p == 0);
`endif
      return {fs, 11'(x), 11'(y), hsn, vsn, on};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One clock: count the edge if released, then compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) n++;
      @(negedge clk);
      chk("trk0", 64'(o0), 64'(ref_out(n, 640, 16, 96, 48, 480, 10, 2, 33)));
      chk("trk1", 64'(o1), 64'(ref_out(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)));
   endtask

   // Drop reset between edges, check the asynchronous return, hold, release.
   task automatic async_reset(input int hold);
      @(posedge clk);
      if (rst_n) n++;
      #4 rst_n = 1'b0;
      #1 n = 0;
      chk("arst0", 64'(o0), 64'(ref_out(0, 640, 16, 96, 48, 480, 10, 2, 33)));
      chk("arst1", 64'(o1), 64'(ref_out(0, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB)));
      repeat (hold) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int hs_low, first_hs, first_off, on_cnt, vs_low, first_vs, diff, fs_cnt;
      logic [2:0] fa [SFRAME];
      logic [2:0] fb [SFRAME];

      // Reset state.
      repeat (3) tick();
      chk("rst_x",  64'(vga0.pixel_x),   64'd799);
      chk("rst_y",  64'(vga0.pixel_y),   64'd524);
      chk("rst_hs", 64'(vga0.VGA_HSYNC), 64'd1);
      chk("rst_vs", 64'(vga0.VGA_VSYNC), 64'd1);
      chk("rst_on", 64'(vga0.on_screen), 64'd0);
      chk("rst_fs", 64'(fs0),            64'd0);

      // First edge after release lands on (0,0), visible.
      rst_n = 1'b1;
      hs_low = 0; first_hs = -1; first_off = -1;
      for (int i = 0; i < 800; i++) begin
         tick();
         if (i == 0) begin
            chk("rel_x",  64'(vga0.pixel_x),   64'd0);
            chk("rel_y",  64'(vga0.pixel_y),   64'd0);
            chk("rel_on", 64'(vga0.on_screen), 64'd1);
         end
         if (!vga0.VGA_HSYNC) begin
            hs_low++;
            if (first_hs < 0) first_hs = int'(vga0.pixel_x);
         end
         if (!vga0.on_screen && first_off < 0) first_off = int'(vga0.pixel_x);
      end
      chk("hs_width", 64'(hs_low),    64'd96);
      chk("hs_start", 64'(first_hs),  64'd656);
      chk("on_fall",  64'(first_off), 64'd640);
      chk("end_x",    64'(vga0.pixel_x), 64'd799);
      tick();
      chk("wrap_x", 64'(vga0.pixel_x), 64'd0);
      chk("wrap_y", 64'(vga0.pixel_y), 64'd1);

      // Mid-line reset at x=300.
      repeat (300) tick();
      chk("pre_rst_x", 64'(vga0.pixel_x), 64'd300);
      async_reset(2);

      // Two full frames of the shrunken instance from a fresh release.
      on_cnt = 0; vs_low = 0; first_vs = -1; fs_cnt = 0;
      for (int i = 0; i < 2 * SFRAME; i++) begin
         tick();
         if (i < SFRAME) begin
            fa[i] = {vga1.VGA_HSYNC, vga1.VGA_VSYNC, vga1.on_screen};
            if (vga1.on_screen) on_cnt++;
            if (!vga1.VGA_VSYNC) begin
               vs_low++;
               if (first_vs < 0) first_vs = int'(vga1.pixel_y);
            end
         end else begin
            fb[i - SFRAME] = {vga1.VGA_HSYNC, vga1.VGA_VSYNC, vga1.on_screen};
         end
         if (fs1) fs_cnt++;
      end
      diff = 0;
      for (int i = 0; i < SFRAME; i++) if (fa[i] !== fb[i]) diff++;
      chk("frm_on",    64'(on_cnt),   64'(SHV * SVV));
      chk("frm_vslow", 64'(vs_low),   64'(SVS * (SHV + SHF + SHS + SHB)));
      chk("frm_vs_y",  64'(first_vs), 64'(SVV + SVF));
      chk("frm_per",   64'(diff),     64'd0);
`ifdef VGA_TIMING_FRAME_START_EN
      chk("frm_fs",    64'(fs_cnt),   64'd2);
`endif

      // Randomised run lengths and asynchronous resets.
      for (int r = 0; r < 10; r++) begin
         int len = int'($urandom_range(1, 1500));
         repeat (len) tick();
         async_reset(int'($urandom_range(1, 3)));
      end
      repeat (int'($urandom_range(50, 500))) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
